// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
//
// CPU-side initiator for the memory request bus served by the address decoder.
// Arbitrates the instruction-fetch port and the data port, then runs one
// word-aligned 32-bit bus transaction at a time using a full 4-phase handshake
// (strobe up, ack up, strobe down, ack down). Partial-byte stores are done as
// read-modify-write. Every handshake phase has an ack timeout so that a dead
// responder cannot hang the CPU.
//
// Parameters
//   TIMEOUT_CYCLES  cycles to wait for m_ack rise (REQ) or fall (DROP)
//   CNT_W           timeout counter width, must hold TIMEOUT_CYCLES
//
// Ports
//   clk, rst                 clock, async active-high reset
//   if_req/if_addr           fetch request (level, held until if_done)
//   if_rdata/if_done/if_err  fetch word, completion pulse, timeout flag
//   d_req/d_we/d_addr        data request, store select, byte address
//   d_wdata/d_be             lane-aligned store data and byte enables
//   d_rdata/d_done/d_err     load word (old word on RMW), pulse, timeout flag
//   m_addr/m_wdata           bus address (word aligned) and write data
//   m_ren/m_wen              bus read / write strobes (never both high)
//   m_ack/m_rdata            responder ack and read data
// -----------------------------------------------------------------------------
module mem_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   // instruction fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   output logic        if_err,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        d_err,
   // memory bus
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_ren,
   output logic        m_wen,
   input  logic        m_ack,
   input  logic [31:0] m_rdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_DROP = 3'd2,
      WR_REQ  = 3'd3,
      WR_DROP = 3'd4,
      RESP    = 3'd5
   } state_t;

   localparam logic             GNT_IF   = 1'b0;
   localparam logic             GNT_D    = 1'b1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q, grant_d;
   logic              rmw_q, rmw_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rd_buf_q, rd_buf_d;
   logic [31:0]       m_addr_q, m_addr_d;
   logic [31:0]       m_wdata_q, m_wdata_d;
   logic              m_ren_q, m_ren_d;
   logic              m_wen_q, m_wen_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic              if_done_q, if_done_d;
   logic              if_err_q, if_err_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              d_done_q, d_done_d;
   logic              d_err_q, d_err_d;

   logic              gnt;
   logic              resp_go;
   logic              tmo;
   logic [31:0]       be_mask;
   logic [31:0]       merge;

   // Bus is word addressed; the low address bits only matter to the CPU.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

   assign be_mask = {{8{d_be[3]}}, {8{d_be[2]}}, {8{d_be[1]}}, {8{d_be[0]}}};
   assign merge   = (rd_buf_q & ~be_mask) | (d_wdata & be_mask);
   assign tmo     = (cnt_q == TMO_LAST);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      rmw_d        = rmw_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      rd_buf_d     = rd_buf_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_ren_d      = m_ren_q;
      m_wen_d      = m_wen_q;
      // completion outputs are pulses: low unless entering RESP
      if_rdata_d   = 32'h0;
      if_done_d    = 1'b0;
      if_err_d     = 1'b0;
      d_rdata_d    = 32'h0;
      d_done_d     = 1'b0;
      d_err_d      = 1'b0;
      gnt          = GNT_IF;
      resp_go      = 1'b0;

      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               // Round-robin only matters on a conflict; a lone requester
               // does not disturb the fairness history.
               if (if_req && d_req) begin
                  gnt          = (last_grant_q == GNT_IF) ? GNT_D : GNT_IF;
                  last_grant_d = gnt;
               end else begin
                  gnt = d_req ? GNT_D : GNT_IF;
               end
               grant_d  = gnt;
               err_d    = 1'b0;
               rmw_d    = 1'b0;
               rd_buf_d = 32'h0;
               if (gnt == GNT_IF) begin
                  m_addr_d = {if_addr[31:2], 2'b00};
                  m_ren_d  = 1'b1;
                  state_d  = RD_REQ;
               end else begin
                  m_addr_d = {d_addr[31:2], 2'b00};
                  if (!d_we) begin
                     m_ren_d = 1'b1;
                     state_d = RD_REQ;
                  end else if (d_be == 4'hF) begin
                     m_wdata_d = d_wdata;
                     m_wen_d   = 1'b1;
                     state_d   = WR_REQ;
                  end else if (d_be == 4'h0) begin
                     // nothing to write: complete without touching the bus
                     state_d = RESP;
                     resp_go = 1'b1;
                  end else begin
                     rmw_d   = 1'b1;
                     m_ren_d = 1'b1;
                     state_d = RD_REQ;
                  end
               end
            end
         end

         RD_REQ: begin
            if (m_ack) begin
               rd_buf_d = m_rdata;
               m_ren_d  = 1'b0;
               state_d  = RD_DROP;
            end else if (tmo) begin
               m_ren_d = 1'b0;
               err_d   = 1'b1;
               state_d = RD_DROP;
            end
         end

         RD_DROP: begin
            if (!m_ack) begin
               // A failed read leaves nothing valid to merge, so the
               // write half of an RMW is abandoned.
               if (rmw_q && !err_q) begin
                  m_wdata_d = merge;
                  m_wen_d   = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  state_d = RESP;
                  resp_go = 1'b1;
               end
            end else if (tmo) begin
               state_d = RESP;
               resp_go = 1'b1;
            end
         end

         WR_REQ: begin
            if (m_ack) begin
               m_wen_d = 1'b0;
               state_d = WR_DROP;
            end else if (tmo) begin
               m_wen_d = 1'b0;
               err_d   = 1'b1;
               state_d = WR_DROP;
            end
         end

         WR_DROP: begin
            if (!m_ack || tmo) begin
               state_d = RESP;
               resp_go = 1'b1;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            m_ren_d = 1'b0;
            m_wen_d = 1'b0;
         end
      endcase

      // Timeout counter restarts on every state change and only runs
      // while waiting on the responder.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == RD_REQ || state_q == RD_DROP ||
                   state_q == WR_REQ || state_q == WR_DROP) begin
         cnt_d = cnt_q + CNT_ONE;
      end

      // Done/err/rdata are registered on entry to RESP so the pulse is
      // visible for exactly the one cycle spent in RESP.
      if (resp_go) begin
         if (grant_d == GNT_D) begin
            d_done_d  = 1'b1;
            d_err_d   = err_d;
            d_rdata_d = rd_buf_d;
         end else begin
            if_done_d  = 1'b1;
            if_err_d   = err_d;
            if_rdata_d = rd_buf_d;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_IF;
         grant_q      <= GNT_IF;
         rmw_q        <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         rd_buf_q     <= 32'h0;
         m_addr_q     <= 32'h0;
         m_wdata_q    <= 32'h0;
         m_ren_q      <= 1'b0;
         m_wen_q      <= 1'b0;
         if_rdata_q   <= 32'h0;
         if_done_q    <= 1'b0;
         if_err_q     <= 1'b0;
         d_rdata_q    <= 32'h0;
         d_done_q     <= 1'b0;
         d_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         rmw_q        <= rmw_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         rd_buf_q     <= rd_buf_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_ren_q      <= m_ren_d;
         m_wen_q      <= m_wen_d;
         if_rdata_q   <= if_rdata_d;
         if_done_q    <= if_done_d;
         if_err_q     <= if_err_d;
         d_rdata_q    <= d_rdata_d;
         d_done_q     <= d_done_d;
         d_err_q      <= d_err_d;
      end
   end

   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign m_ren    = m_ren_q;
   assign m_wen    = m_wen_q;
   assign if_rdata = if_rdata_q;
   assign if_done  = if_done_q;
   assign if_err   = if_err_q;
   assign d_rdata  = d_rdata_q;
   assign d_done   = d_done_q;
   assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_master
//
// Scoreboard bench: each request pushes its expected completion (port, rdata,
// err) and, for bus writes, the expected write beat. A negedge monitor pops
// and compares when the DUT pulses done or raises m_wen. A small responder
// model with programmable ack delay (or no ack at all) backs a 16-word memory.
// -----------------------------------------------------------------------------
module tb_mem_bus_master;

   typedef struct packed {
      logic        port;   // 0 = fetch, 1 = data
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk, rst;
   logic        if_req;
   logic [31:0] if_addr, if_rdata;
   logic        if_done, if_err;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        d_done, d_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_ren, m_wen, m_ack;

   mem_bus_master #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_done(if_done), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_ren(m_ren), .m_wen(m_wen),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sbq[$];
   wr_t  wq[$];

   logic [31:0] mem [16];
   int          ack_dly   = 0;
   logic        never_ack = 1'b0;
   int          rsp_cnt;
   int          ren_cyc = 0;
   int          wen_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Responder: acks ack_dly cycles after seeing a strobe, holds ack until
   // the strobe drops, then releases it the following cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ack   <= 1'b0;
         m_rdata <= 32'h0;
         rsp_cnt <= 0;
      end else if ((m_ren || m_wen) && !m_ack && !never_ack) begin
         if (rsp_cnt >= ack_dly) begin
            m_ack   <= 1'b1;
            rsp_cnt <= 0;
            if (m_ren) m_rdata <= mem[m_addr[5:2]];
            else       mem[m_addr[5:2]] = m_wdata;
         end else begin
            rsp_cnt <= rsp_cnt + 1;
         end
      end else if (!m_ren && !m_wen) begin
         m_ack   <= 1'b0;
         rsp_cnt <= 0;
      end
   end

   // Monitor
   logic        prev_if_done = 1'b0, prev_d_done = 1'b0, prev_wen = 1'b0;
   logic        prev_act = 1'b0, prev_strb = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   exp_t        e;
   wr_t         w;

   always @(negedge clk) begin
      if (!rst) begin
         if (m_ren) ren_cyc++;
         if (m_wen) wen_cyc++;
         if (m_ren || m_wen) chk("ren_wen_overlap", 32'(m_ren & m_wen), 32'h0);
         if ((m_ren || m_wen) && !prev_strb) chk("ack_low_at_strobe", 32'(m_ack), 32'h0);
         if ((m_ren || m_wen || m_ack) && prev_act) chk("addr_stable", m_addr, prev_addr);
         if (m_wen && !prev_wen) begin
            if (wq.size() == 0) chk("unexpected_write", 32'h1, 32'h0);
            else begin
               w = wq.pop_front();
               chk("wr_addr", m_addr, w.addr);
               chk("wr_data", m_wdata, w.data);
            end
         end
         if (if_done || d_done) begin
            chk("done_one_port", 32'(if_done & d_done), 32'h0);
            chk("done_pulse", {30'h0, prev_if_done & if_done, prev_d_done & d_done}, 32'h0);
            if (sbq.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
            else begin
               e = sbq.pop_front();
               chk("done_port", 32'(d_done), 32'(e.port));
               chk("rdata", d_done ? d_rdata : if_rdata, e.rdata);
               chk("err", 32'(d_done ? d_err : if_err), 32'(e.err));
            end
         end
      end
      prev_if_done = if_done;
      prev_d_done  = d_done;
      prev_wen     = m_wen;
      prev_strb    = m_ren | m_wen;
      prev_act     = m_ren | m_wen | m_ack;
      prev_addr    = m_addr;
   end

   task automatic outs_zero(input string tag);
      chk({tag, "_addr"},  m_addr, 32'h0);
      chk({tag, "_wdata"}, m_wdata, 32'h0);
      chk({tag, "_rdata"}, if_rdata | d_rdata, 32'h0);
      chk({tag, "_bits"},  {26'h0, m_ren, m_wen, if_done, if_err, d_done, d_err}, 32'h0);
   endtask

   // Drive one request and wait (bounded) until its completion is scored.
   task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] exp_rd, input logic exp_err, output int lat);
      exp_t x;
      x.port = port; x.rdata = exp_rd; x.err = exp_err;
      sbq.push_back(x);
      if (port) begin
         d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
      end else begin
         if_addr = addr; if_req = 1'b1;
      end
      lat = 0;
      while (sbq.size() != 0 && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
      end
      if (sbq.size() != 0) begin
         chk("txn_no_done", 32'h1, 32'h0);
         sbq.delete();
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic push_exp(input logic port, input logic [31:0] rd, input logic err);
      exp_t x;
      x.port = port; x.rdata = rd; x.err = err;
      sbq.push_back(x);
   endtask

   initial begin
      int  lat;
      wr_t wx;
      for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 + i;
      mem[4] = 32'hDEAD_BEEF;
      mem[8] = 32'h1122_3344;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      outs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // plain load, slow responder
      ack_dly = 3;
      run_txn(1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, lat);

      // partial store: read old word, write merged word
      ack_dly = 0;
      wx.addr = 32'h8000_0020; wx.data = 32'h1122_AB44; wq.push_back(wx);
      run_txn(1'b1, 1'b1, 32'h8000_0022, 32'h0000_AB00, 4'b0010, 32'h1122_3344, 1'b0, lat);
      chk("rmw_mem", mem[8], 32'h1122_AB44);
      chk("wq_drained", 32'(wq.size()), 32'h0);

      // full store then read it back
      wx.addr = 32'h8000_0008; wx.data = 32'hCAFE_F00D; wq.push_back(wx);
      run_txn(1'b1, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, lat);
      run_txn(1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, lat);
      run_txn(1'b0, 1'b0, 32'h0000_0006, 32'h0, 4'h0, 32'hA5A5_0001, 1'b0, lat);

      // both ports held: first conflict after reset goes to data, then alternate
      push_exp(1'b1, 32'hDEAD_BEEF, 1'b0);
      push_exp(1'b0, 32'hA5A5_0001, 1'b0);
      push_exp(1'b1, 32'hDEAD_BEEF, 1'b0);
      push_exp(1'b0, 32'hA5A5_0001, 1'b0);
      d_we = 1'b0; d_addr = 32'h8000_0010; if_addr = 32'h0000_0004;
      d_req = 1'b1; if_req = 1'b1;
      lat = 0;
      while (sbq.size() != 0 && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("alt_remaining", 32'(sbq.size()), 32'h0);
      sbq.delete();
      d_req = 1'b0; if_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // dead responder: fetch aborts after 8 strobe cycles with error
      never_ack = 1'b1; ren_cyc = 0;
      run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 1'b1, lat);
      chk("tmo_ren_cycles", 32'(ren_cyc), 32'd8);
      // RMW whose read times out must not write
      wen_cyc = 0;
      run_txn(1'b1, 1'b1, 32'h8000_0030, 32'h0000_00FF, 4'b0011, 32'h0, 1'b1, lat);
      chk("tmo_rmw_no_write", 32'(wen_cyc), 32'h0);
      never_ack = 1'b0;
      run_txn(1'b0, 1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'hA5A5_0005, 1'b0, lat);

      // empty store: no bus cycle, quick completion
      wen_cyc = 0; ren_cyc = 0;
      run_txn(1'b1, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, lat);
      chk("be0_latency_le2", 32'(lat <= 2), 32'h1);
      chk("be0_no_bus", 32'(wen_cyc + ren_cyc), 32'h0);

      // reset in the middle of a read: outputs clear at once, no done
      never_ack = 1'b1;
      d_we = 1'b0; d_addr = 32'h8000_0010; d_req = 1'b1;
      lat = 0;
      while (!m_ren && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rst_mid_ren_seen", 32'(m_ren), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      outs_zero("rst_mid");
      d_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      never_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      run_txn(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h1122_AB44, 1'b0, lat);

      chk("sb_empty", 32'(sbq.size() + wq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
